// File: rtl/imem_pkg.sv
// Shared definitions for the instruction memory and its boot/load controller.
package imem_pkg;

    localparam int          IMEM_DEPTH = 256;
    localparam int          IMEM_AW    = 8;
    localparam logic [31:0] NOP_INSTR  = 32'h0000_0000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR_LO,
        ST_HDR_HI,
        ST_DATA,
        ST_CSUM,
        ST_RUN,
        ST_ERR
    } imem_state_t;

    // States in which a load frame is in progress and loader bytes are taken.
    function automatic logic is_busy(input imem_state_t s);
        return (s == ST_HDR_LO) || (s == ST_HDR_HI) || (s == ST_DATA) || (s == ST_CSUM);
    endfunction

endpackage

// File: rtl/imem_word_asm.sv
// Byte-to-word assembler: packs four little-endian bytes into a 32-bit word,
// pulses word_valid the cycle after the fourth byte, and keeps the frame XOR.
module imem_word_asm (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        shift_en,
    input  logic [7:0]  data_byte,
    output logic [31:0] word,
    output logic        word_valid,
    output logic        word_last,
    output logic [7:0]  csum
);

    logic [1:0]  idx;
    logic [23:0] shreg;

    assign word_last = shift_en && (idx == 2'd3);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx        <= 2'd0;
            shreg      <= 24'd0;
            word       <= 32'd0;
            word_valid <= 1'b0;
            csum       <= 8'd0;
        end else begin
            word_valid <= word_last;
            if (clr) begin
                idx  <= 2'd0;
                csum <= 8'd0;
            end else if (shift_en) begin
                idx  <= idx + 2'd1;
                csum <= csum ^ data_byte;
                // Right shift so the first byte of the word ends up in [7:0].
                shreg <= {data_byte, shreg[23:8]};
                if (word_last) begin
                    word <= {data_byte, shreg};
                end
            end
        end
    end

endmodule

// File: rtl/imem_boot_ctrl.sv
// Boot/load controller and address-port arbiter for the single-port imem:
// loads a framed byte stream into imem, then hands the port to the fetch PC.
module imem_boot_ctrl
    import imem_pkg::*;
#(
    parameter int          DEPTH    = IMEM_DEPTH,
    parameter int          AW       = IMEM_AW,
    parameter logic [31:0] NOP      = NOP_INSTR,
    parameter bit          BOOT_RUN = 1'b1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load_start,
    input  logic          ld_valid,
    input  logic [7:0]    ld_data,
    output logic          ld_ready,
    input  logic [63:0]   pc,
    input  logic [31:0]   mem_rdata,
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic [31:0]   mem_wdata,
    output logic [31:0]   instr,
    output logic          cpu_rst_n,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [AW:0]   words_loaded
);

    imem_state_t   state_q;
    imem_state_t   state_d;
    logic [15:0]   cnt_q;
    logic [15:0]   hdr_n;
    logic [AW-1:0] addr_q;
    logic          accept;
    logic          last_word;
    logic          asm_clr;
    logic          asm_shift;
    logic          word_last;
    logic [7:0]    csum;
    logic          pc_unused;

    assign accept    = ld_valid && ld_ready;
    assign hdr_n     = {ld_data, cnt_q[7:0]};
    assign last_word = (16'(words_loaded) + 16'd1) == cnt_q;
    assign asm_clr   = (state_q == ST_HDR_HI) && accept;
    assign asm_shift = (state_q == ST_DATA) && accept;

    // Fetch owns the address port only while running; pc[1:0] and the high bits are dropped.
    assign mem_addr  = (state_q == ST_RUN) ? pc[AW+1:2] : addr_q;
    assign instr     = (state_q == ST_RUN) ? mem_rdata : NOP;
    assign pc_unused = ^{pc[63:AW+2], pc[1:0]};

    imem_word_asm u_asm (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (asm_clr),
        .shift_en   (asm_shift),
        .data_byte  (ld_data),
        .word       (mem_wdata),
        .word_valid (mem_we),
        .word_last  (word_last),
        .csum       (csum)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (BOOT_RUN) begin
                    state_d = ST_RUN;
                end else if (load_start) begin
                    state_d = ST_HDR_LO;
                end
            end
            ST_HDR_LO: begin
                if (accept) begin
                    state_d = ST_HDR_HI;
                end
            end
            ST_HDR_HI: begin
                if (accept) begin
                    if (hdr_n > 16'(DEPTH)) begin
                        state_d = ST_ERR;
                    end else if (hdr_n == 16'd0) begin
                        state_d = ST_CSUM;
                    end else begin
                        state_d = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                // Completion is decided in the write cycle, when words_loaded still names the word.
                if (mem_we && last_word) begin
                    state_d = ST_CSUM;
                end
            end
            ST_CSUM: begin
                if (accept) begin
                    state_d = (ld_data == csum) ? ST_RUN : ST_ERR;
                end
            end
            ST_RUN, ST_ERR: begin
                if (load_start) begin
                    state_d = ST_HDR_LO;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ld_ready     <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
            cpu_rst_n    <= 1'b0;
            words_loaded <= '0;
            cnt_q        <= 16'd0;
            addr_q       <= '0;
        end else begin
            // Flags follow the next state so they change on the same edge as the state.
            ld_ready  <= is_busy(state_d) && !word_last;
            busy      <= is_busy(state_d);
            done      <= (state_d == ST_RUN);
            cpu_rst_n <= (state_d == ST_RUN);
            err       <= (state_d == ST_ERR);
            if (word_last) begin
                addr_q <= words_loaded[AW-1:0];
            end
            if ((state_q == ST_HDR_LO) && accept) begin
                cnt_q[7:0] <= ld_data;
            end
            if (asm_clr) begin
                cnt_q        <= hdr_n;
                words_loaded <= '0;
            end else if (mem_we) begin
                words_loaded <= words_loaded + {{AW{1'b0}}, 1'b1};
            end
        end
    end

endmodule

// File: tb/tb_imem_boot_ctrl.sv
// Bench for imem_boot_ctrl: directed frames plus randomized gapped frames
// checked against a frame-level reference of the expected imem writes.
module tb_imem_boot_ctrl;

    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          load_start;
    logic          ld_valid;
    logic [7:0]    ld_data;
    logic [63:0]   pc;
    logic [31:0]   mem_rdata;
    logic          ld_ready;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [31:0]   mem_wdata;
    logic [31:0]   instr;
    logic          cpu_rst_n;
    logic          busy;
    logic          done;
    logic          err;
    logic [AW:0]   words_loaded;

    logic [63:0]   b_pc;
    logic [31:0]   b_mem_rdata;
    logic          b_ld_ready;
    logic [AW-1:0] b_mem_addr;
    logic          b_mem_we;
    logic [31:0]   b_mem_wdata;
    logic [31:0]   b_instr;
    logic          b_cpu_rst_n;
    logic          b_busy;
    logic          b_done;
    logic          b_err;
    logic [AW:0]   b_words_loaded;

    int tests = 0;
    int fails = 0;
    int overlap = 0;
    logic        seeded = 1'b0;
    logic [31:0] imem      [256];
    logic [31:0] init_mem  [256];
    logic [31:0] model_mem [256];
    logic [39:0] wq [$];
    logic [7:0]  frame [$];
    logic [31:0] exp_words [$];

    imem_boot_ctrl #(.DEPTH(256), .AW(AW), .NOP(32'h0), .BOOT_RUN(1'b0)) dut (
        .clk(clk), .rst_n(rst_n), .load_start(load_start), .ld_valid(ld_valid),
        .ld_data(ld_data), .ld_ready(ld_ready), .pc(pc), .mem_rdata(mem_rdata),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .instr(instr),
        .cpu_rst_n(cpu_rst_n), .busy(busy), .done(done), .err(err),
        .words_loaded(words_loaded)
    );

    imem_boot_ctrl #(.DEPTH(256), .AW(AW), .NOP(32'h0), .BOOT_RUN(1'b1)) dut_boot (
        .clk(clk), .rst_n(rst_n), .load_start(1'b0), .ld_valid(1'b0),
        .ld_data(8'h00), .ld_ready(b_ld_ready), .pc(b_pc), .mem_rdata(b_mem_rdata),
        .mem_addr(b_mem_addr), .mem_we(b_mem_we), .mem_wdata(b_mem_wdata), .instr(b_instr),
        .cpu_rst_n(b_cpu_rst_n), .busy(b_busy), .done(b_done), .err(b_err),
        .words_loaded(b_words_loaded)
    );

    always #5 clk = ~clk;

    assign mem_rdata   = imem[mem_addr];
    assign b_mem_rdata = {24'hC0FFEE, b_mem_addr};

    always @(posedge clk) begin
        if (!seeded) begin
            for (int i = 0; i < 256; i++) imem[i] <= init_mem[i];
            seeded <= 1'b1;
        end else if (mem_we) begin
            imem[mem_addr] <= mem_wdata;
            wq.push_back({mem_addr, mem_wdata});
        end
        if (mem_we && ld_ready) overlap++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_frame();
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
    endtask

    task automatic send_frame(input bit gaps, input bit pokes);
        for (int i = 0; i < frame.size(); i++) begin
            int guard;
            if (gaps) begin
                int g;
                g = $urandom_range(0, 3);
                ld_valid = 1'b0;
                for (int j = 0; j < g; j++) begin
                    load_start = pokes && ($urandom_range(0, 1) == 1);
                    tick();
                    load_start = 1'b0;
                end
            end
            ld_data  = frame[i];
            ld_valid = 1'b1;
            guard    = 0;
            while (!ld_ready && guard < 50) begin
                tick();
                guard++;
            end
            if (!ld_ready) check("ld_ready_wait", ld_ready, 1'b1);
            tick();
            ld_valid = 1'b0;
        end
    endtask

    // Reference: word k of the frame is its k-th group of four bytes, little-endian.
    task automatic build_frame(input int n, input bit bad);
        logic [7:0]  cs;
        logic [31:0] w;
        logic [15:0] n16;
        frame.delete();
        exp_words.delete();
        cs  = 8'h00;
        n16 = n[15:0];
        frame.push_back(n16[7:0]);
        frame.push_back(n16[15:8]);
        for (int k = 0; k < n; k++) begin
            w = $urandom;
            exp_words.push_back(w);
            for (int b = 0; b < 4; b++) begin
                frame.push_back(w[8*b +: 8]);
                cs = cs ^ w[8*b +: 8];
            end
        end
        frame.push_back(bad ? (cs ^ 8'h01) : cs);
    endtask

    task automatic check_writes();
        int n;
        check("write_count", wq.size(), exp_words.size());
        n = (wq.size() < exp_words.size()) ? wq.size() : exp_words.size();
        for (int k = 0; k < n; k++) begin
            check($sformatf("write%0d", k), wq[k], {k[7:0], exp_words[k]});
        end
        for (int k = 0; k < exp_words.size(); k++) model_mem[k] = exp_words[k];
    endtask

    task automatic check_fetch();
        logic [7:0] widx;
        pc = {$urandom, $urandom};
        #1;
        widx = pc[9:2];
        check("fetch_addr", mem_addr, widx);
        check("fetch_instr", instr, model_mem[widx]);
    endtask

    initial begin
        rst_n = 1'b0; load_start = 1'b0; ld_valid = 1'b0; ld_data = 8'h00;
        pc = 64'h0; b_pc = 64'h8;
        for (int i = 0; i < 256; i++) begin
            init_mem[i]  = $urandom | 32'h1;
            model_mem[i] = init_mem[i];
        end
        repeat (3) tick();

        check("rst_ld_ready", ld_ready, 1'b0);
        check("rst_mem_we", mem_we, 1'b0);
        check("rst_mem_wdata", mem_wdata, 32'h0);
        check("rst_mem_addr", mem_addr, 8'h0);
        check("rst_cpu_rst_n", cpu_rst_n, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_err", err, 1'b0);
        check("rst_words_loaded", words_loaded, 9'h0);
        check("rst_instr", instr, 32'h0);
        check("rst_boot_done", b_done, 1'b0);

        rst_n = 1'b1;
        tick();
        check("boot_done", b_done, 1'b1);
        check("boot_cpu_rst_n", b_cpu_rst_n, 1'b1);
        check("boot_mem_addr", b_mem_addr, 8'h02);
        check("boot_instr", b_instr, 32'hC0FFEE02);
        tick();
        check("idle_done", done, 1'b0);
        check("idle_busy", busy, 1'b0);
        check("idle_ld_ready", ld_ready, 1'b0);

        // Directed good frame
        wq.delete();
        frame     = '{8'h02, 8'h00, 8'h05, 8'h00, 8'h10, 8'h20, 8'h13, 8'h00, 8'h00, 8'h00, 8'h26};
        exp_words = '{32'h20100005, 32'h00000013};
        pc = 64'h10;
        start_frame();
        check("load_busy", busy, 1'b1);
        check("load_ld_ready", ld_ready, 1'b1);
        check("load_instr_nop", instr, 32'h0);
        check("load_cpu_held", cpu_rst_n, 1'b0);
        send_frame(1'b0, 1'b0);
        check_writes();
        check("good_done", done, 1'b1);
        check("good_words", words_loaded, 9'd2);
        check("good_cpu_rst_n", cpu_rst_n, 1'b1);
        check("good_err", err, 1'b0);
        check("good_busy", busy, 1'b0);
        check_fetch();
        check_fetch();

        // Bad checksum, then recovery
        wq.delete();
        frame[10] = 8'h27;
        start_frame();
        check("restart_cpu_held", cpu_rst_n, 1'b0);
        check("restart_done", done, 1'b0);
        check("restart_busy", busy, 1'b1);
        send_frame(1'b0, 1'b0);
        check_writes();
        check("bad_csum_err", err, 1'b1);
        check("bad_csum_cpu_held", cpu_rst_n, 1'b0);
        check("bad_csum_done", done, 1'b0);
        check("bad_csum_instr", instr, 32'h0);
        start_frame();
        check("err_cleared", err, 1'b0);
        wq.delete();
        build_frame(3, 1'b0);
        send_frame(1'b0, 1'b0);
        check_writes();
        check("recover_done", done, 1'b1);

        // Oversized header
        wq.delete();
        frame = '{8'h01, 8'h01};
        exp_words.delete();
        start_frame();
        send_frame(1'b0, 1'b0);
        check("big_err", err, 1'b1);
        check("big_words", words_loaded, 9'd0);
        check("big_ld_ready", ld_ready, 1'b0);
        repeat (3) tick();
        check_writes();

        // Empty frame
        start_frame();
        frame = '{8'h00, 8'h00, 8'h00};
        send_frame(1'b0, 1'b0);
        check("empty_done", done, 1'b1);
        check("empty_words", words_loaded, 9'd0);
        check_writes();

        // Randomized gapped frames with ignored load_start pulses
        for (int it = 0; it < 5; it++) begin
            int n;
            n = $urandom_range(1, 6);
            wq.delete();
            build_frame(n, 1'b0);
            start_frame();
            send_frame(1'b1, 1'b1);
            check_writes();
            check("rand_done", done, 1'b1);
            check("rand_words", words_loaded, n[8:0]);
            check_fetch();
        end
        check("ready_during_we", overlap, 0);

        // Reset after three of four data bytes
        wq.delete();
        start_frame();
        frame = '{8'h01, 8'h00, 8'hAA, 8'hBB, 8'hCC};
        send_frame(1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_ld_ready", ld_ready, 1'b0);
        check("mid_rst_words", words_loaded, 9'd0);
        check("mid_rst_cpu_rst_n", cpu_rst_n, 1'b0);
        check("mid_rst_mem_wdata", mem_wdata, 32'h0);
        check("mid_rst_mem_addr", mem_addr, 8'h0);
        check("mid_rst_instr", instr, 32'h0);
        repeat (3) tick();
        check("mid_rst_no_write", wq.size(), 0);
        check("mid_rst_mem_we", mem_we, 1'b0);
        rst_n = 1'b1;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/imem_boot_ctrl.md
Name: imem_boot_ctrl

Overview:
Boot/load controller and port arbiter for the single-port instruction memory of the pipelined core.
- After reset, or on request, it accepts a framed little-endian byte stream and writes it into imem as 32-bit words, holding the core in reset meanwhile.
- Once loading finishes it hands the imem address port to the fetch PC.
- Checksum and length errors latch an error state, and the core stays held.

Parameters:
- DEPTH, 256, imem depth in 32-bit words.
- AW, 8, imem word-address width (clog2(DEPTH)).
- NOP, 32'h00000000, instruction presented to fetch while not running.
- BOOT_RUN, 1, 1 = go IDLE->RUN right after reset (execute existing image); 0 = wait in IDLE for load_start.

Ports:
- clk  in  1  core clock.
- rst_n  in  1  asynchronous active-low reset.
- load_start  in  1  one-cycle pulse; begin a new load frame.
- ld_valid  in  1  loader byte valid.
- ld_data  in  8  loader byte.
- ld_ready  out  1  controller accepts byte this cycle.
- pc  in  64  fetch byte address.
- mem_rdata  in  32  imem read data (combinational read).
- mem_addr  out  AW  imem word address.
- mem_we  out  1  imem write strobe.
- mem_wdata  out  32  imem write data.
- instr  out  32  instruction to fetch stage.
- cpu_rst_n  out  1  active-low hold for the core pipeline.
- busy  out  1  load frame in progress.
- done  out  1  in RUN.
- err  out  1  in ERR.
- words_loaded  out  AW+1  words written in the current or last frame.

Behaviour:
- Frame format: CNT_LO, CNT_HI (16-bit word count N), then 4*N data bytes (little-endian per word, word k at address k), then one CSUM byte = XOR of all data bytes (header bytes excluded).
- States: IDLE, HDR_LO, HDR_HI, DATA, CSUM, RUN, ERR. All state and outputs are registered, except instr and mem_addr in RUN.
- Reset (async): state=IDLE. Outputs: ld_ready=0, mem_we=0, mem_wdata=0, mem_addr=0, cpu_rst_n=0, busy=0, done=0, err=0, words_loaded=0. Internal byte index, XOR accumulator and count register are cleared.
- IDLE:
  - BOOT_RUN=1 -> RUN next cycle.
  - Otherwise wait; load_start -> HDR_LO.
- Byte handshake: a byte is accepted on a cycle with ld_valid & ld_ready. ld_ready=1 exactly in HDR_LO, HDR_HI, DATA and CSUM; 0 elsewhere, including the cycle mem_we is high.
- HDR_LO -> HDR_HI on accept.
- HDR_HI, on accept:
  - N > DEPTH -> ERR.
  - N == 0 -> CSUM.
  - Otherwise -> DATA.
  - In all cases words_loaded is cleared and the XOR accumulator is cleared.
- DATA:
  - Bytes shift into a 32-bit assembler: byte0 goes to bits [7:0], byte3 to bits [31:24].
  - On the 4th accepted byte: next cycle mem_we=1 for exactly one cycle, with mem_addr=words_loaded[AW-1:0] and mem_wdata=the assembled word. words_loaded then increments.
  - After word N is written -> CSUM.
- CSUM, on accept:
  - Byte == accumulator -> RUN.
  - Else -> ERR.
- RUN:
  - cpu_rst_n=1, done=1.
  - mem_addr=pc[AW+1:2] combinationally; pc[1:0] is ignored, and higher pc bits wrap.
  - instr=mem_rdata.
  - mem_we=0.
- Not RUN: instr=NOP.
- ERR: err=1, cpu_rst_n=0. Leaves only on load_start -> HDR_LO, which clears err.
- load_start:
  - In RUN -> HDR_LO. cpu_rst_n drops to 0 in the same cycle the state changes.
  - In HDR_LO through CSUM: ignored. A frame is never aborted except by rst_n.
- busy=1 in HDR_LO, HDR_HI, DATA and CSUM.
- rst_n asserted mid-frame: immediate return to IDLE. Partially written imem contents are undefined; words_loaded=0.
- No timeout. A stalled loader holds the current state indefinitely.

Decomposition:
- Shared package imem_pkg: state enum (IDLE..ERR), NOP_INSTR, IMEM_DEPTH, IMEM_AW. The instruction memory also uses these.
- One natural sub-module: imem_word_asm (byte-to-word assembler with 2-bit index, XOR accumulator and word_valid pulse). The FSM, address mux and instr mux stay in the top.

Test Plan:
- BOOT_RUN=1, release rst_n, pc=64'h8 -> RUN within 1 cycle, cpu_rst_n=1, mem_addr=2, instr=mem_rdata.
- BOOT_RUN=0, load_start, bytes 02 00 | 05 00 10 20 | 13 00 00 00 | CSUM=0x26 -> writes addr0=32'h20100005, addr1=32'h00000013; done=1, words_loaded=2. While loading, instr=0 and cpu_rst_n=0.
- Same frame with CSUM=0x27 -> ERR, err=1, cpu_rst_n=0. A new load_start clears err, and a good frame then reaches RUN.
- Header 01 01 (N=257) -> ERR right after the CNT_HI accept; no mem_we ever asserted.
- ld_valid toggled randomly with gaps mid-word, plus load_start pulses during DATA -> identical writes to the gap-free case; load_start has no effect.
- rst_n asserted after 3 of 4 data bytes -> all outputs at reset values asynchronously; mem_we never pulses for the partial word.
